// File: rtl/mem_token_bucket_mc.sv
// Multi-channel token-bucket DRAM contention injector feeding one shared fixed-latency in-flight pipe.
// Build option MEM_TB_STRICT_PRIORITY_EN: lowest eligible channel wins (no round-robin pointer).
module mem_token_bucket_mc #(
    parameter int NUM_CH               = 4,
    parameter int SIZE_WIDTH           = 16,
    parameter int TOKEN_WIDTH          = 16,
    parameter int SIZE_TO_TOKENS_SHIFT = 3,
    parameter int LAT_WIDTH            = 16,
    parameter int INFLIGHT_DEPTH       = 8,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [NUM_CH-1:0]                             req_valid,
    input  logic [NUM_CH*SIZE_WIDTH-1:0]                  req_size_bytes,
    output logic [NUM_CH-1:0]                             req_ready,
    output logic                                          resp_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] resp_ch,
    output logic [SIZE_WIDTH-1:0]                         resp_size_bytes,
    input  logic [LAT_WIDTH-1:0]                          cfg_latency,
    input  logic                                          cfg_enable_contention,
    input  logic [NUM_CH*8-1:0]                           cfg_tokens_per_cycle,
    input  logic [NUM_CH*TOKEN_WIDTH-1:0]                 cfg_token_capacity,
    output logic [NUM_CH*TOKEN_WIDTH-1:0]                 tokens_level,
    output logic [NUM_CH*CNT_WIDTH-1:0]                   token_stall_cycles,
    output logic [NUM_CH*CNT_WIDTH-1:0]                   contention_events,
    output logic [CNT_WIDTH-1:0]                          total_reqs,
    output logic [CNT_WIDTH-1:0]                          total_resp,
    output logic                                          busy
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (INFLIGHT_DEPTH > 1) ? $clog2(INFLIGHT_DEPTH) : 1;
    localparam int TS_W  = LAT_WIDTH + 1;
    localparam int BW    = TOKEN_WIDTH + 9;
    localparam int CMP_W = (SIZE_WIDTH + 1 > TOKEN_WIDTH) ? SIZE_WIDTH + 1 : TOKEN_WIDTH;
    localparam logic [SIZE_WIDTH:0] ROUND     = (SIZE_WIDTH+1)'((1 << SIZE_TO_TOKENS_SHIFT) - 1);
    localparam logic [TS_W-1:0]     TS_HALF   = TS_W'(1) << LAT_WIDTH;
    localparam logic [PTR_W:0]      DEPTH_CNT = (PTR_W+1)'(INFLIGHT_DEPTH);

    logic                  init_pending;
    logic [TS_W-1:0]       now;
    logic [NUM_CH-1:0]     elig;
    logic                  found;
    logic [CH_W-1:0]       win;
    logic                  accept;
    logic [SIZE_WIDTH-1:0] win_size;
    logic [TS_W-1:0]       lat_eff;

    logic [CH_W-1:0]       f_ch   [INFLIGHT_DEPTH];
    logic [SIZE_WIDTH-1:0] f_size [INFLIGHT_DEPTH];
    logic [TS_W-1:0]       f_due  [INFLIGHT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  fifo_full, fifo_empty;
    logic [CH_W-1:0]       head_ch;
    logic [SIZE_WIDTH-1:0] head_size;
    logic [TS_W-1:0]       head_due, age;
    logic                  head_valid, pop, bypass, push, pop_fifo;

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign busy       = !fifo_empty;

    // Handshake: req_ready is combinational from req_valid and state, at most one bit set;
    // a transfer happens on the clk edge where req_valid[c] && req_ready[c].
    assign accept    = found;
    assign req_ready = found ? (NUM_CH'(1) << win) : '0;
    assign win_size  = req_size_bytes[win*SIZE_WIDTH +: SIZE_WIDTH];
    assign lat_eff   = (cfg_latency == '0) ? TS_W'(1) : TS_W'(cfg_latency);

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            logic [SIZE_WIDTH-1:0]  size;
            logic [SIZE_WIDTH:0]    raw_cost;
            logic [TOKEN_WIDTH-1:0] cap, cost, tokens;
            logic [7:0]             tpc;
            logic [BW-1:0]          sum;
            logic                   stall, stall_q, consume;
            logic [CNT_WIDTH-1:0]   stall_cnt, event_cnt;

            assign size     = req_size_bytes[g*SIZE_WIDTH +: SIZE_WIDTH];
            assign cap      = cfg_token_capacity[g*TOKEN_WIDTH +: TOKEN_WIDTH];
            assign tpc      = cfg_tokens_per_cycle[g*8 +: 8];
            assign raw_cost = ({1'b0, size} + ROUND) >> SIZE_TO_TOKENS_SHIFT;
            // Clamping to capacity keeps oversized requests from waiting forever.
            assign cost     = (CMP_W'(raw_cost) > CMP_W'(cap)) ? cap : TOKEN_WIDTH'(raw_cost);
            assign elig[g]  = req_valid[g] && !init_pending && !fifo_full
                              && (!cfg_enable_contention || tokens >= cost);
            assign stall    = req_valid[g] && cfg_enable_contention && !init_pending && (tokens < cost);
            assign consume  = req_ready[g] && cfg_enable_contention;
            assign sum      = BW'(tokens) - (consume ? BW'(cost) : '0) + BW'(tpc);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    tokens    <= '0;
                    stall_q   <= 1'b0;
                    stall_cnt <= '0;
                    event_cnt <= '0;
                end else begin
                    if (init_pending) tokens <= cap;
                    else              tokens <= (sum > BW'(cap)) ? cap : sum[TOKEN_WIDTH-1:0];
                    stall_q <= stall;
                    if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
                    if (stall && !stall_q && ~&event_cnt) event_cnt <= event_cnt + 1'b1;
                end
            end

            assign tokens_level[g*TOKEN_WIDTH +: TOKEN_WIDTH]   = tokens;
            assign token_stall_cycles[g*CNT_WIDTH +: CNT_WIDTH] = stall_cnt;
            assign contention_events[g*CNT_WIDTH +: CNT_WIDTH]  = event_cnt;
        end
    endgenerate

`ifdef MEM_TB_STRICT_PRIORITY_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                found = 1'b1;
                win   = CH_W'(i);
            end
        end
    end
`else
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W:0]   rr_idx;

    always_comb begin
        found  = 1'b0;
        win    = '0;
        rr_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (rr_idx >= (CH_W+1)'(NUM_CH)) rr_idx = rr_idx - (CH_W+1)'(NUM_CH);
            if (!found && elig[rr_idx[CH_W-1:0]]) begin
                found = 1'b1;
                win   = rr_idx[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    rr_ptr <= '0;
        else if (accept) rr_ptr <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
    end
`endif

    // An empty pipe lets a latency-1 request respond straight from the accept cycle.
    assign head_valid = !fifo_empty || accept;
    assign head_ch    = fifo_empty ? win : f_ch[rd_ptr];
    assign head_size  = fifo_empty ? win_size : f_size[rd_ptr];
    assign head_due   = fifo_empty ? (now + lat_eff) : f_due[rd_ptr];
    assign age        = now + TS_W'(1) - head_due;
    assign pop        = head_valid && (age < TS_HALF);
    assign bypass     = pop && fifo_empty;
    assign push       = accept && !bypass;
    assign pop_fifo   = pop && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            f_ch[wr_ptr]   <= win;
            f_size[wr_ptr] <= win_size;
            f_due[wr_ptr]  <= now + lat_eff;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_pending    <= 1'b1;
            now             <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            resp_valid      <= 1'b0;
            resp_ch         <= '0;
            resp_size_bytes <= '0;
            total_reqs      <= '0;
            total_resp      <= '0;
        end else begin
            init_pending <= 1'b0;
            now          <= now + TS_W'(1);
            if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop_fifo)      count <= count + (PTR_W+1)'(1);
            else if (!push && pop_fifo) count <= count - (PTR_W+1)'(1);
            resp_valid <= pop;
            if (pop) begin
                resp_ch         <= head_ch;
                resp_size_bytes <= head_size;
            end
            if (accept && ~&total_reqs) total_reqs <= total_reqs + 1'b1;
            if (pop && ~&total_resp)    total_resp <= total_resp + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_token_bucket_mc.sv
// Directed bench for mem_token_bucket_mc: accept-time scoreboard checks every response's channel, size and cycle.
`timescale 1ns/1ps
module tb_mem_token_bucket_mc;
  localparam int NUM_CH = 4;
  localparam int SW = 16;
  localparam int TW = 16;
  localparam int LW = 16;
  localparam int CW = 32;
  localparam int QW = 8 + SW + 32;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [NUM_CH-1:0]      req_valid = '0;
  logic [NUM_CH*SW-1:0]   req_size_bytes = '0;
  logic [NUM_CH-1:0]      req_ready;
  logic                   resp_valid;
  logic [1:0]             resp_ch;
  logic [SW-1:0]          resp_size_bytes;
  logic [LW-1:0]          cfg_latency = 16'd1;
  logic                   cfg_enable_contention = 1'b1;
  logic [NUM_CH*8-1:0]    cfg_tokens_per_cycle = '0;
  logic [NUM_CH*TW-1:0]   cfg_token_capacity = '0;
  logic [NUM_CH*TW-1:0]   tokens_level;
  logic [NUM_CH*CW-1:0]   token_stall_cycles;
  logic [NUM_CH*CW-1:0]   contention_events;
  logic [CW-1:0]          total_reqs;
  logic [CW-1:0]          total_resp;
  logic                   busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int n_acc = 0;
  int acc_cyc [0:31];
  int acc_ch  [0:31];
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] e;

  mem_token_bucket_mc dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_size_bytes(req_size_bytes), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ch(resp_ch), .resp_size_bytes(resp_size_bytes),
    .cfg_latency(cfg_latency), .cfg_enable_contention(cfg_enable_contention),
    .cfg_tokens_per_cycle(cfg_tokens_per_cycle), .cfg_token_capacity(cfg_token_capacity),
    .tokens_level(tokens_level), .token_stall_cycles(token_stall_cycles),
    .contention_events(contention_events), .total_reqs(total_reqs),
    .total_resp(total_resp), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor: pop/compare responses, then record new accepts as expected responses
  always @(negedge clk) begin
    if (reset_n) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_ch", 64'(resp_ch), 64'(e[QW-1 -: 8]));
          check("resp_size", 64'(resp_size_bytes), 64'(e[32 +: SW]));
          check("resp_cycle", 64'(cyc), 64'(e[31:0]));
        end
      end
      if (req_valid != '0) check("ready_onehot", 64'($countones(req_ready) > 1), 64'd0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_valid[c] && req_ready[c])
          exp_q.push_back({8'(c), req_size_bytes[c*SW +: SW],
                           32'(cyc + ((cfg_latency == 0) ? 1 : int'(cfg_latency)))});
      end
    end
  end

  // driver tasks
  task automatic set_cfg(input int lat, input logic en, input int tpc, input int cap);
    cfg_latency = LW'(lat);
    cfg_enable_contention = en;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_tokens_per_cycle[c*8 +: 8] = 8'(tpc);
      cfg_token_capacity[c*TW +: TW] = TW'(cap);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    req_valid = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic hold_valid(input logic [NUM_CH-1:0] mask, input logic [SW-1:0] sz,
                            input int n_target, input int budget);
    int b;
    b = 0;
    n_acc = 0;
    for (int c = 0; c < NUM_CH; c++) req_size_bytes[c*SW +: SW] = sz;
    req_valid = mask;
    while (n_acc < n_target && b < budget) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_valid[c] && req_ready[c] && n_acc < 32) begin
          acc_cyc[n_acc] = cyc;
          acc_ch[n_acc] = c;
          n_acc++;
        end
      end
      b++;
    end
    @(posedge clk); #1 req_valid = '0;
    check("accept_count", 64'(n_acc), 64'(n_target));
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || busy) && b < budget) begin
      @(posedge clk);
      b++;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // reset state
    #2;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_tokens", 64'(tokens_level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // 1: 32B (4 tokens) at tpc=4 never stalls; FIFO fills at 8, refills when first resp leaves
    set_cfg(10, 1'b1, 4, 32);
    do_reset();
    hold_valid(4'b0001, 16'd32, 20, 300);
    check("t1_first_accept", 64'(acc_cyc[0] - rel_cyc), 64'd1);
    check("t1_burst8", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
    check("t1_ninth", 64'(acc_cyc[8] - acc_cyc[0]), 64'd10);
    wait_drain(200);
    check("t1_stall", 64'(token_stall_cycles[0 +: CW]), 64'd0);
    check("t1_total_reqs", 64'(total_reqs), 64'd20);
    check("t1_total_resp", 64'(total_resp), 64'd20);
    check("t1_level", 64'(tokens_level[0 +: TW]), 64'd32);

    // 2: 64B (8 tokens) drains the bucket: 7 back-to-back then one per two cycles
    set_cfg(4, 1'b1, 4, 32);
    do_reset();
    hold_valid(4'b0001, 16'd64, 20, 300);
    check("t2_burst7", 64'(acc_cyc[6] - acc_cyc[0]), 64'd6);
    check("t2_gap", 64'(acc_cyc[7] - acc_cyc[6]), 64'd2);
    check("t2_last", 64'(acc_cyc[19] - acc_cyc[0]), 64'd32);
    wait_drain(200);
    check("t2_stall", 64'(token_stall_cycles[0 +: CW]), 64'd13);
    check("t2_events", 64'(contention_events[0 +: CW]), 64'd13);
    check("t2_total_resp", 64'(total_resp), 64'd20);

    // 3: arbitration between two, then three channels
    set_cfg(3, 1'b1, 1, 32);
    do_reset();
    hold_valid(4'b0011, 16'd8, 8, 50);
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_TB_STRICT_PRIORITY_EN
      check("t3_grant2", 64'(acc_ch[i]), 64'd0);
`else
      check("t3_grant2", 64'(acc_ch[i]), 64'(i % 2));
`endif
    end
    check("t3_every_cycle", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
    wait_drain(100);
    do_reset();
    hold_valid(4'b0111, 16'd8, 6, 50);
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_TB_STRICT_PRIORITY_EN
      check("t3_grant3", 64'(acc_ch[i]), 64'd0);
`else
      check("t3_grant3", 64'(acc_ch[i]), 64'(i % 3));
`endif
    end
    wait_drain(100);

    // 4: contention off, tpc=0: tokens ignored and not consumed; FIFO full blocks until first resp
    set_cfg(20, 1'b0, 0, 32);
    do_reset();
    hold_valid(4'b0001, 16'd64, 9, 100);
    check("t4_burst8", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
    check("t4_ninth", 64'(acc_cyc[8] - acc_cyc[0]), 64'd20);
    wait_drain(100);
    check("t4_stall", 64'(token_stall_cycles[0 +: CW]), 64'd0);
    check("t4_level", 64'(tokens_level[0 +: TW]), 64'd32);

    // 5: 1024B clamps to capacity; then capacity lowered below level
    set_cfg(5, 1'b1, 4, 32);
    do_reset();
    hold_valid(4'b0001, 16'd1024, 1, 20);
    check("t5_accept_at_full", 64'(acc_cyc[0] - rel_cyc), 64'd1);
    check("t5_level_after", 64'(tokens_level[0 +: TW]), 64'd4);
    @(posedge clk); #1;
    check("t5_level_refill", 64'(tokens_level[0 +: TW]), 64'd8);
    repeat (8) @(posedge clk);
    #1 cfg_token_capacity[0 +: TW] = 16'd10;
    @(posedge clk); #1;
    check("t5_cap_clamp", 64'(tokens_level[0 +: TW]), 64'd10);
    wait_drain(50);

    // 7: latency 0 behaves as 1, responses come the cycle after accept
    set_cfg(0, 1'b1, 4, 32);
    do_reset();
    hold_valid(4'b0001, 16'd8, 3, 20);
    check("t7_back_to_back", 64'(acc_cyc[2] - acc_cyc[0]), 64'd2);
    wait_drain(20);
    check("t7_total_resp", 64'(total_resp), 64'd3);

    // 6: reset with three requests in flight
    set_cfg(20, 1'b1, 4, 32);
    do_reset();
    hold_valid(4'b0001, 16'd8, 3, 20);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_total_reqs", 64'(total_reqs), 64'd0);
    check("t6_tokens", 64'(tokens_level), 64'd0);
    check("t6_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #3;
    req_size_bytes[0 +: SW] = 16'd8;
    req_valid = 4'b0001;
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_ready_init", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    check("t6_level_loaded", 64'(tokens_level[0 +: TW]), 64'd32);
    repeat (30) @(posedge clk);
    #1;
    check("t6_no_stale_resp", 64'(total_resp), 64'd0);
    check("t6_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
